// File: rtl/game_pkg.sv
// Shared types for the Sokoban game-flow sequencer: state encoding, command
// codes, game-state register select codes and the Moore output decode.
package game_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_INIT    = 4'd1,
        ST_WAIT    = 4'd2,
        ST_MOVE    = 4'd3,
        ST_RETRACT = 4'd4,
        ST_HOLD    = 4'd5,
        ST_CLEAR   = 4'd6,
        ST_NEXT    = 4'd7,
        ST_OVER    = 4'd8,
        ST_LOSE    = 4'd9
    } game_state_e;

    localparam logic [2:0] CMD_MOVE    = 3'd0;
    localparam logic [2:0] CMD_RETRY   = 3'd1;
    localparam logic [2:0] CMD_RETRACT = 3'd2;
    localparam logic [2:0] CMD_NEXT    = 3'd3;
    localparam logic [2:0] CMD_HOLD    = 3'd4;

    localparam logic [1:0] SEL_LOAD    = 2'b00;
    localparam logic [1:0] SEL_MOVE    = 2'b01;
    localparam logic [1:0] SEL_RETRACT = 2'b11;

    typedef struct packed {
        logic       state_en;
        logic [1:0] sel;
        logic       stage_up;
        logic       win;
        logic       lose;
        logic       held;
    } flow_out_t;

    // Counter controls issued by the FSM; init wins over everything else.
    typedef struct packed {
        logic init;
        logic inc;
        logic dec;
        logic tick;
    } cnt_ctrl_t;

    function automatic flow_out_t decode_outputs(input game_state_e s);
        flow_out_t o;
        o = '0;
        case (s)
            ST_RESET, ST_INIT: o.state_en = 1'b1;
            ST_MOVE: begin
                o.state_en = 1'b1;
                o.sel      = SEL_MOVE;
            end
            ST_RETRACT: begin
                o.state_en = 1'b1;
                o.sel      = SEL_RETRACT;
            end
            ST_HOLD: o.held     = 1'b1;
            ST_NEXT: o.stage_up = 1'b1;
            ST_OVER: o.win      = 1'b1;
            ST_LOSE: o.lose     = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/game_attempt_counters.sv
// Per-attempt counters: steps taken, retracts available and countdown ticks.
// All saturation and flooring rules live here; the FSM only strobes controls.
module game_attempt_counters
    import game_pkg::*;
#(
    parameter int STEP_W     = 8,
    parameter int UNDO_DEPTH = 8,
    parameter int UNDO_W     = $clog2(UNDO_DEPTH + 1),
    parameter int TIME_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  cnt_ctrl_t         ctrl,
    input  logic [TIME_W-1:0] time_limit,
    output logic [STEP_W-1:0] step,
    output logic [UNDO_W-1:0] undo_avail,
    output logic [TIME_W-1:0] time_left
);

    localparam logic [STEP_W-1:0] STEP_MAX = '1;
    localparam logic [UNDO_W-1:0] UNDO_MAX = UNDO_W'(UNDO_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            step       <= '0;
            undo_avail <= '0;
            time_left  <= '0;
        end else if (ctrl.init) begin
            step       <= '0;
            undo_avail <= '0;
            time_left  <= time_limit;
        end else begin
            if (ctrl.inc) begin
                if (step != STEP_MAX)
                    step <= step + STEP_W'(1);
                if (undo_avail < UNDO_MAX)
                    undo_avail <= undo_avail + UNDO_W'(1);
            end else if (ctrl.dec) begin
                if (step != '0)
                    step <= step - STEP_W'(1);
                if (undo_avail != '0)
                    undo_avail <= undo_avail - UNDO_W'(1);
            end
            if (ctrl.tick && time_left != '0)
                time_left <= time_left - TIME_W'(1);
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: accepts decoded commands, drives load/move/retract to
// the game-state register and reports clear, win, lose and hold status.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int CELLS      = 64,
    parameter int STAGE_W    = 2,
    parameter int LAST_STAGE = 3,
    parameter int STEP_W     = 8,
    parameter int UNDO_DEPTH = 8,
    parameter int UNDO_W     = $clog2(UNDO_DEPTH + 1),
    parameter int TIME_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd,
    input  logic               move_ok,
    input  logic [CELLS-1:0]   box,
    input  logic [CELLS-1:0]   destination,
    input  logic [STAGE_W-1:0] stage,
    input  logic [STEP_W-1:0]  step_limit,
    input  logic [TIME_W-1:0]  time_limit,
    input  logic               tick,
    output logic               state_en,
    output logic [1:0]         sel,
    output logic               stage_up,
    output logic               win,
    output logic               lose,
    output logic               held,
    output logic [STEP_W-1:0]  step,
    output logic [UNDO_W-1:0]  undo_avail,
    output logic [TIME_W-1:0]  time_left
);

    localparam logic [STAGE_W-1:0] FINAL_STAGE = STAGE_W'(LAST_STAGE);

    game_state_e state_q, state_d;
    cnt_ctrl_t   ctrl;
    flow_out_t   outs;

    logic cmd_move, cmd_retry, cmd_retract, cmd_next, cmd_hold;
    logic solved, out_of_steps, out_of_time;

    assign cmd_move    = cmd_valid && (cmd == CMD_MOVE);
    assign cmd_retry   = cmd_valid && (cmd == CMD_RETRY);
    assign cmd_retract = cmd_valid && (cmd == CMD_RETRACT);
    assign cmd_next    = cmd_valid && (cmd == CMD_NEXT);
    assign cmd_hold    = cmd_valid && (cmd == CMD_HOLD);

    assign solved       = (box == destination);
    assign out_of_steps = (step_limit != '0) && (step >= step_limit);
    assign out_of_time  = (time_limit != '0) && (time_left == '0);

    always_ff @(posedge clk) begin
        if (reset || restart)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                ctrl.init = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // The timer runs in WAIT even on the cycle WAIT is left.
                ctrl.tick = tick;
                if (solved)
                    state_d = (stage == FINAL_STAGE) ? ST_OVER : ST_CLEAR;
                else if (out_of_steps || out_of_time)
                    state_d = ST_LOSE;
                else if (cmd_retry)
                    state_d = ST_INIT;
                else if (cmd_retract && undo_avail != '0)
                    state_d = ST_RETRACT;
                else if (cmd_move && move_ok)
                    state_d = ST_MOVE;
                else if (cmd_hold)
                    state_d = ST_HOLD;
            end
            ST_MOVE: begin
                ctrl.inc = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_RETRACT: begin
                ctrl.dec = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_HOLD: begin
                if (cmd_hold)
                    state_d = ST_WAIT;
                else if (cmd_retry)
                    state_d = ST_INIT;
            end
            ST_CLEAR: if (cmd_next) state_d = ST_NEXT;
            ST_NEXT:  state_d = ST_INIT;
            // NEXT from LOSE replays the same stage; no stage_up is issued.
            ST_LOSE:  if (cmd_retry || cmd_next) state_d = ST_INIT;
            ST_OVER:  state_d = ST_OVER;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb outs = decode_outputs(state_q);

    assign state_en = outs.state_en;
    assign sel      = outs.sel;
    assign stage_up = outs.stage_up;
    assign win      = outs.win;
    assign lose     = outs.lose;
    assign held     = outs.held;

    game_attempt_counters #(
        .STEP_W    (STEP_W),
        .UNDO_DEPTH(UNDO_DEPTH),
        .UNDO_W    (UNDO_W),
        .TIME_W    (TIME_W)
    ) u_counters (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .time_limit(time_limit),
        .step      (step),
        .undo_avail(undo_avail),
        .time_left (time_left)
    );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: reset, table-driven command vectors,
// hand-written limit/timer/clear/win sequences and a randomized model check.
module tb_game_flow_ctrl;

    localparam logic [2:0] C_MOVE = 3'd0, C_RETRY = 3'd1, C_RETRACT = 3'd2,
                           C_NEXT = 3'd3, C_HOLD = 3'd4, C_NONE = 3'd7;
    localparam int STEP_SAT = 255;
    localparam int UNDO_SAT = 8;

    logic        clk = 1'b0;
    logic        reset, restart, cmd_valid, move_ok, tick;
    logic [2:0]  cmd;
    logic [63:0] box, destination;
    logic [1:0]  stage;
    logic [7:0]  step_limit;
    logic [11:0] time_limit;
    logic        state_en, stage_up, win, lose, held;
    logic [1:0]  sel;
    logic [7:0]  step;
    logic [3:0]  undo_avail;
    logic [11:0] time_left;

    int n_tests = 0;
    int n_fail  = 0;

    game_flow_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart), .cmd_valid(cmd_valid),
        .cmd(cmd), .move_ok(move_ok), .box(box), .destination(destination),
        .stage(stage), .step_limit(step_limit), .time_limit(time_limit),
        .tick(tick), .state_en(state_en), .sel(sel), .stage_up(stage_up),
        .win(win), .lose(lose), .held(held), .step(step),
        .undo_avail(undo_avail), .time_left(time_left)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] c;
        logic       ok;
        int         exp_step;
        int         exp_undo;
        int         exp_pulses;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [2:0] c, input logic ok, input int s,
                                    input int u, input int p, input logic [1:0] sl);
        vec_t v;
        v.c = c; v.ok = ok; v.exp_step = s; v.exp_undo = u; v.exp_pulses = p; v.exp_sel = sl;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: strobe one command, then observe three cycles.
    task automatic do_cmd(input logic [2:0] c, input logic ok, output int pulses,
                          output int ups, output logic [1:0] sel_seen);
        pulses = 0; ups = 0; sel_seen = 2'b00;
        cmd_valid = 1'b1; cmd = c; move_ok = ok;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd = C_NONE; move_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (state_en) begin
                pulses++;
                sel_seen = sel;
            end
            if (stage_up) ups++;
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk);
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    initial begin
        int p, u, ms, mu, ep, r;
        logic [1:0] sl, esel;
        logic [2:0] rc;
        logic rok;

        reset = 1'b1; restart = 1'b0; cmd_valid = 1'b0; cmd = C_NONE; move_ok = 1'b0;
        tick = 1'b0; box = 64'h0000_0000_00F0_0000; destination = 64'h0000_0000_0F00_0000;
        stage = 2'd0; step_limit = '0; time_limit = '0;

        // Reset state, then RESET/INIT write-enables, then idle WAIT
        @(negedge clk);
        @(negedge clk);
        check("reset_state_en", state_en, 1);
        check("reset_sel", sel, 0);
        check("reset_status", {stage_up, win, lose, held}, 0);
        check("reset_step", step, 0);
        check("reset_undo", undo_avail, 0);
        check("reset_time", time_left, 0);
        reset = 1'b0;
        @(negedge clk);
        check("init_state_en", state_en, 1);
        check("init_sel", sel, 0);
        @(negedge clk);
        check("wait_state_en", state_en, 0);
        check("wait_step", step, 0);
        check("wait_undo", undo_avail, 0);

        // Command table
        for (int i = 1; i <= 10; i++)
            add_vec(C_MOVE, 1'b1, i, (i > UNDO_SAT) ? UNDO_SAT : i, 1, 2'b01);
        add_vec(C_RETRACT, 1'b1, 9, 7, 1, 2'b11);
        add_vec(C_RETRACT, 1'b0, 8, 6, 1, 2'b11);
        add_vec(C_RETRACT, 1'b1, 7, 5, 1, 2'b11);
        add_vec(C_MOVE,    1'b0, 7, 5, 0, 2'b00);
        add_vec(3'd5,      1'b1, 7, 5, 0, 2'b00);
        add_vec(3'd6,      1'b1, 7, 5, 0, 2'b00);
        add_vec(C_NEXT,    1'b1, 7, 5, 0, 2'b00);
        add_vec(C_RETRY,   1'b0, 0, 0, 1, 2'b00);
        add_vec(C_RETRACT, 1'b1, 0, 0, 0, 2'b00);
        add_vec(C_MOVE,    1'b1, 1, 1, 1, 2'b01);
        add_vec(C_RETRACT, 1'b0, 0, 0, 1, 2'b11);
        foreach (vecs[k]) begin
            do_cmd(vecs[k].c, vecs[k].ok, p, u, sl);
            check($sformatf("vec%0d_step", k), step, vecs[k].exp_step);
            check($sformatf("vec%0d_undo", k), undo_avail, vecs[k].exp_undo);
            check($sformatf("vec%0d_pulses", k), p, vecs[k].exp_pulses);
            check($sformatf("vec%0d_sel", k), sl, vecs[k].exp_sel);
        end

        // Step limit: 5 moves on an unsolved board lose; RETRY reloads
        step_limit = 8'd5;
        for (int i = 0; i < 5; i++) do_cmd(C_MOVE, 1'b1, p, u, sl);
        check("steplim_lose", lose, 1);
        check("steplim_step", step, 5);
        do_cmd(C_MOVE, 1'b1, p, u, sl);
        check("steplim_move_dropped", p, 0);
        do_cmd(C_RETRY, 1'b0, p, u, sl);
        check("steplim_retry_pulse", p, 1);
        check("steplim_retry_step", step, 0);
        check("steplim_retry_lose", lose, 0);
        step_limit = '0;

        // Timer: expired count loses; HOLD freezes ticks
        time_limit = 12'd3;
        @(negedge clk);
        check("timer_zero_lose", lose, 1);
        do_cmd(C_RETRY, 1'b0, p, u, sl);
        check("timer_load", time_left, 3);
        tick_n(1);
        check("timer_tick1", time_left, 2);
        do_cmd(C_HOLD, 1'b0, p, u, sl);
        check("hold_held", held, 1);
        tick_n(2);
        check("hold_frozen", time_left, 2);
        do_cmd(C_HOLD, 1'b0, p, u, sl);
        check("hold_release", held, 0);
        tick_n(2);
        check("timer_zero", time_left, 0);
        @(negedge clk);
        check("timer_lose", lose, 1);
        time_limit = '0;
        do_cmd(C_NEXT, 1'b0, p, u, sl);
        check("lose_next_pulse", p, 1);
        check("lose_next_no_stage_up", u, 0);
        check("lose_next_cleared", lose, 0);

        // Solve stage 1 together with a MOVE: win check wins, move dropped
        stage = 2'd1;
        destination = box;
        do_cmd(C_MOVE, 1'b1, p, u, sl);
        check("clear_move_dropped", p, 0);
        check("clear_step", step, 0);
        destination = 64'h0000_0000_0F00_0000;
        do_cmd(C_MOVE, 1'b1, p, u, sl);
        check("clear_cmd_dropped", p, 0);
        do_cmd(C_NEXT, 1'b0, p, u, sl);
        check("next_stage_up", u, 1);
        check("next_init_pulse", p, 1);
        check("next_init_sel", sl, 0);

        // Solve last stage: win holds until restart
        do_cmd(C_MOVE, 1'b1, p, u, sl);
        do_cmd(C_MOVE, 1'b1, p, u, sl);
        stage = 2'd3;
        destination = box;
        @(negedge clk);
        check("over_win", win, 1);
        do_cmd(C_RETRY, 1'b0, p, u, sl);
        check("over_retry_dropped", p, 0);
        check("over_win_held", win, 1);
        destination = 64'h0000_0000_0F00_0000;
        @(negedge clk);
        check("over_absorbing", win, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_win", win, 0);
        check("restart_state_en", state_en, 1);
        @(negedge clk);
        @(negedge clk);
        check("restart_step", step, 0);
        stage = 2'd0;

        // Randomized commands against an abstract counter model
        ms = 0; mu = 0;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            rok = ($urandom_range(0, 3) != 0);
            case (r)
                0, 1, 2, 3, 8, 9: rc = C_MOVE;
                4, 5:             rc = C_RETRACT;
                6:                rc = C_RETRY;
                default:          rc = 3'($urandom_range(5, 7));
            endcase
            ep = 0; esel = 2'b00;
            if (rc == C_MOVE && rok) begin
                ms = (ms + 1 > STEP_SAT) ? STEP_SAT : ms + 1;
                mu = (mu + 1 > UNDO_SAT) ? UNDO_SAT : mu + 1;
                ep = 1; esel = 2'b01;
            end else if (rc == C_RETRACT && mu > 0) begin
                ms = (ms > 0) ? ms - 1 : 0;
                mu = mu - 1;
                ep = 1; esel = 2'b11;
            end else if (rc == C_RETRY) begin
                ms = 0; mu = 0; ep = 1;
            end
            do_cmd(rc, rok, p, u, sl);
            check($sformatf("rnd%0d_step", i), step, ms);
            check($sformatf("rnd%0d_undo", i), undo_avail, mu);
            check($sformatf("rnd%0d_pulses", i), p, ep);
            check($sformatf("rnd%0d_sel", i), sl, esel);
        end

        // Step counter saturates at all-ones
        for (int i = 0; i < 260; i++) do_cmd(C_MOVE, 1'b1, p, u, sl);
        check("sat_step", step, STEP_SAT);
        check("sat_undo", undo_avail, UNDO_SAT);
        do_cmd(C_RETRACT, 1'b0, p, u, sl);
        check("sat_retract_step", step, STEP_SAT - 1);
        check("sat_retract_undo", undo_avail, UNDO_SAT - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
